// File: rtl/play_engine_pkg.sv
// play_engine_pkg
// Shared control definitions for the PLAY command channel: SRAM word-address
// and sample types, chunk base-address constants, the playback state enum and
// a helper that forms a chunk read address with modulo-2^23 wrap.
package play_engine_pkg;

  localparam int unsigned SRAM_AW  = 23;
  localparam int unsigned SAMPLE_W = 16;

  typedef logic [SRAM_AW-1:0]  sram_addr_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Base latched out of reset, before any chunk has been selected.
  localparam sram_addr_t CHUNK_BASE_RESET = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    OUTPUT,
    PAUSED,
    DONE,
    REARM
  } play_state_t;

  // Chunk read address; the sum wraps past the top of SRAM with no error.
  function automatic sram_addr_t chunk_addr(input sram_addr_t base,
                                            input sram_addr_t offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/play_sram_reader.sv
// play_sram_reader
// Issues SRAM read strobes and reports when the returned word is valid.
// A valid-flag shift register tracks each strobe for RD_LAT cycles, so the
// data-valid flag lines up with i_sram_rdata in the cycle the SRAM presents it.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_flush          drops every read still in flight
//   i_rd, i_addr     read request and word address from the engine
//   o_sram_addr/rd   SRAM address and one-cycle read strobe
//   i_sram_rdata     SRAM read data
//   o_data/_valid    read data and its valid flag
module play_sram_reader
  import play_engine_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_rd,
  input  logic [SRAM_AW-1:0]  i_addr,
  output logic [SRAM_AW-1:0]  o_sram_addr,
  output logic                o_sram_rd,
  input  logic [SAMPLE_W-1:0] i_sram_rdata,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_data_valid
);

  logic [RD_LAT-1:0] vld_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= i_rd;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign o_sram_rd    = i_rd;
  assign o_sram_addr  = i_rd ? i_addr : '0;
  assign o_data       = i_sram_rdata;
  assign o_data_valid = vld_q[RD_LAT-1];

endmodule

// File: rtl/play_engine.sv
// play_engine
// PLAY command responder: on a start request latches a chunk base address,
// reads CHUNK_WORDS samples from SRAM one at a time and streams them to the
// DAC serializer over valid/ready, honouring pause (at sample boundaries)
// and stop (immediate). Ends with a one-cycle done pulse, then waits for the
// start request to drop before it can be accepted again.
// Build option: PLAY_ENGINE_LOOP_EN -- chunk playback loops until stopped.
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_play_start/select         start level and chunk base word address
//   i_play_pause, i_play_stop   hold position / abort
//   o_play_done, o_busy         completion pulse, active flag
//   o_sram_addr, o_sram_rd      SRAM read address and strobe
//   i_sram_rdata                SRAM read data (RD_LAT cycles after strobe)
//   o_sample, o_sample_valid    PCM sample to the DAC, valid flag
//   i_sample_ready              DAC ready
module play_engine
  import play_engine_pkg::*;
#(
  parameter int unsigned CHUNK_WORDS = 1024,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_play_start,
  input  logic [SRAM_AW-1:0]  i_play_select,
  input  logic                i_play_pause,
  input  logic                i_play_stop,
  output logic                o_play_done,
  output logic                o_busy,
  output logic [SRAM_AW-1:0]  o_sram_addr,
  output logic                o_sram_rd,
  input  logic [SAMPLE_W-1:0] i_sram_rdata,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_valid,
  input  logic                i_sample_ready
);

  localparam int unsigned OFF_W = $clog2(CHUNK_WORDS);

  play_state_t      state_q, state_d;
  sram_addr_t       base_q;
  logic [OFF_W-1:0] offset_q;
  sample_t          sample_q;
  logic             valid_q;

  logic       accept, capture, handshake, stop_now, rd_stb;
  logic       rd_valid;
  sample_t    rd_data;
  sram_addr_t rd_addr;
`ifndef PLAY_ENGINE_LOOP_EN
  logic       last_word;

  assign last_word = (offset_q == '1);
`endif

  assign rd_addr = chunk_addr(base_q, sram_addr_t'(offset_q));

  play_sram_reader #(
    .RD_LAT(RD_LAT)
  ) u_reader (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (stop_now),
    .i_rd         (rd_stb),
    .i_addr       (rd_addr),
    .o_sram_addr  (o_sram_addr),
    .o_sram_rd    (o_sram_rd),
    .i_sram_rdata (i_sram_rdata),
    .o_data       (rd_data),
    .o_data_valid (rd_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stop wins over every transition in the active states. The WAIT count is
  // carried by the reader's valid pipeline: its flag rises exactly on the
  // RD_LAT-th WAIT cycle, and a stop flush guarantees a stale flag never
  // reaches a later read.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    stop_now  = 1'b0;
    rd_stb    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_play_start) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (i_play_stop) begin
          stop_now = 1'b1;
          state_d  = DONE;
        end else begin
          rd_stb  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_play_stop) begin
          stop_now = 1'b1;
          state_d  = DONE;
        end else if (rd_valid) begin
          capture = 1'b1;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (i_play_stop) begin
          stop_now = 1'b1;
          state_d  = DONE;
        end else if (i_sample_ready) begin
          handshake = 1'b1;
`ifdef PLAY_ENGINE_LOOP_EN
          state_d = i_play_pause ? PAUSED : FETCH;
`else
          if (last_word) begin
            state_d = DONE;
          end else begin
            state_d = i_play_pause ? PAUSED : FETCH;
          end
`endif
        end
      end
      PAUSED: begin
        if (i_play_stop) begin
          stop_now = 1'b1;
          state_d  = DONE;
        end else if (!i_play_pause) begin
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = REARM;
      end
      REARM: begin
        if (!i_play_start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Offset is a power-of-two counter, so the increment past the last word
  // wraps to 0 on its own; that is the loop-build behaviour.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      base_q   <= CHUNK_BASE_RESET;
      offset_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        base_q   <= i_play_select;
        offset_q <= '0;
      end
      if (capture) begin
        sample_q <= rd_data;
        valid_q  <= 1'b1;
      end
      if (handshake) begin
        valid_q  <= 1'b0;
        offset_q <= offset_q + OFF_W'(1);
      end
      if (stop_now) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_play_done    = (state_q == DONE);
  assign o_busy         = (state_q != IDLE) && (state_q != REARM);
  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;

endmodule

// File: tb/tb_play_engine.sv
module tb_play_engine;
  localparam int unsigned CW = 4;
  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, pause, ready, rd, done, busy, valid;
  logic [22:0] select, addr;
  logic [15:0] rdata, sample;

  always #5 clk = ~clk;

  play_engine #(.CHUNK_WORDS(CW), .RD_LAT(RL)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_play_start   (start),
    .i_play_select  (select),
    .i_play_pause   (pause),
    .i_play_stop    (stop),
    .o_play_done    (done),
    .o_busy         (busy),
    .o_sram_addr    (addr),
    .o_sram_rd      (rd),
    .i_sram_rdata   (rdata),
    .o_sample       (sample),
    .o_sample_valid (valid),
    .i_sample_ready (ready)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got 0x%0h, expected none", name, act);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM model: returns the read address as data, RL cycles after the strobe;
  // random garbage on the bus otherwise.
  logic        pipe_v [0:RL];
  logic [22:0] pipe_a [0:RL];
  initial for (int i = 0; i <= int'(RL); i++) begin pipe_v[i] = 1'b0; pipe_a[i] = '0; end
  always @(negedge clk) begin
    for (int i = int'(RL); i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = rd;
    pipe_a[0] = addr;
    rdata = pipe_v[RL] ? pipe_a[RL][15:0] : 16'($urandom);
  end

  // Reference model: a play from base B reads B+k (mod 2^23) and delivers
  // sample (B+k)[15:0] for k = 0..n-1, regardless of pause or backpressure.
  logic [22:0] exp_addr [$];
  logic [15:0] exp_smp  [$];
  task automatic expect_seq(input logic [22:0] base, input int n);
    logic [22:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 23'(k % int'(CW));
      exp_addr.push_back(a);
      exp_smp.push_back(a[15:0]);
    end
  endtask

  // Monitor state
  int rd_in_play, hs_in_play, done_cnt, done_cyc, last_hs_cyc, valid_cnt, stall_cnt;
  int rd_cyc_q [$];
  bit cadence_chk = 1'b0;
  bit prev_stall = 1'b0, prev_done = 1'b0;
  logic [15:0] prev_sample = '0;

  task automatic clear_counters();
    rd_in_play = 0; hs_in_play = 0; done_cnt = 0; done_cyc = -1;
    last_hs_cyc = 0; valid_cnt = 0; stall_cnt = 0;
    rd_cyc_q.delete(); exp_addr.delete(); exp_smp.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(valid), 32'd1);
        check("stall_sample_stable", 32'(sample), 32'(prev_sample));
      end
      if (rd) begin
        rd_in_play++;
        rd_cyc_q.push_back(cyc);
        if (exp_addr.size() == 0) fail_msg("unexpected_read", 32'(addr));
        else check("rd_addr", 32'(addr), 32'(exp_addr.pop_front()));
      end
      if (valid) valid_cnt++;
      if (valid && !ready) stall_cnt++;
      if (valid && ready) begin
        if (cadence_chk && hs_in_play > 0) check("cadence", 32'(cyc - last_hs_cyc), 32'(RL + 2));
        last_hs_cyc = cyc;
        hs_in_play++;
        if (exp_smp.size() == 0) fail_msg("unexpected_sample", 32'(sample));
        else check("sample", 32'(sample), 32'(exp_smp.pop_front()));
      end
      prev_stall  = valid && !ready;
      prev_sample = sample;
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      prev_done = done;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = 10-cycle stall on sample 2
  int ready_mode = 0;
  int bp_left = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: ready = ($urandom_range(0, 2) != 0);
      2: begin
        if (bp_left > 0 && valid && hs_in_play == 2) begin
          ready = 1'b0;
          bp_left--;
        end else ready = 1'b1;
      end
      default: ready = 1'b1;
    endcase
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_addr"},  32'(addr),  32'd0);
    check({tag, "_rd"},    32'(rd),    32'd0);
    check({tag, "_sample"}, 32'(sample), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) tick();
    if (done_cnt == 0) fail_msg("done_timeout", 32'(cyc));
  endtask

  task automatic run_play(input logic [22:0] base, input int mode, input bit rand_pause);
    int acc;
    clear_counters();
    ready_mode = mode;
    expect_seq(base, int'(CW));
    select = base;
    start = 1'b1;
    acc = cyc;
    tick();
    select = ~base;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      if (rand_pause) pause = ($urandom_range(0, 4) == 0);
      tick();
    end
    pause = 1'b0;
    if (done_cnt == 0) fail_msg("done_timeout", 32'(cyc));
    if (rd_cyc_q.size() > 0) check("first_rd_cycle", 32'(rd_cyc_q[0]), 32'(acc + 1));
    else fail_msg("no_reads", 32'(cyc));
    check("reads", 32'(rd_in_play), 32'(CW));
    check("handshakes", 32'(hs_in_play), 32'(CW));
    check("done_after_last_hs", 32'(done_cyc), 32'(last_hs_cyc + 1));
    check("exp_left", 32'(exp_smp.size()), 32'd0);
    repeat (5) tick();
    check("no_restart", 32'(rd_in_play), 32'(CW));
    check("single_done", 32'(done_cnt), 32'd1);
    start = 1'b0;
    repeat (2) tick();
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic pause_test(input logic [22:0] base);
    int p;
    clear_counters();
    ready_mode = 0;
    expect_seq(base, int'(CW));
    select = base;
    start = 1'b1;
    tick();
    for (int i = 0; i < 50 && rd_in_play < 2; i++) tick();
    pause = 1'b1;
    repeat (20) tick();
    check("pause_no_reads", 32'(rd_in_play), 32'd2);
    check("pause_sample1_done", 32'(hs_in_play), 32'd2);
    pause = 1'b0;
    p = cyc;
    wait_done(100);
    if (rd_cyc_q.size() > 2) check("resume_cycle", 32'(rd_cyc_q[2]), 32'(p + 1));
    else fail_msg("resume_missing", 32'(rd_cyc_q.size()));
    check("pause_reads", 32'(rd_in_play), 32'(CW));
    check("pause_hs", 32'(hs_in_play), 32'(CW));
    start = 1'b0;
    repeat (3) tick();
    check("pause_done_cnt", 32'(done_cnt), 32'd1);
  endtask

  task automatic stop_test(input logic [22:0] base);
    int s;
    clear_counters();
    ready_mode = 0;
    expect_seq(base, int'(CW));
    select = base;
    start = 1'b1;
    tick();
    for (int i = 0; i < 50 && rd_in_play < 3; i++) tick();
    stop = 1'b1;
    s = cyc;
    tick();
    stop = 1'b0;
    exp_addr.delete();
    exp_smp.delete();
    wait_done(10);
    check("stop_done_cycle", 32'(done_cyc), 32'(s + 1));
    repeat (50) tick();
    check("stop_no_new_reads", 32'(rd_in_play), 32'd3);
    check("stop_hs", 32'(hs_in_play), 32'd2);
    check("stop_valid_cycles", 32'(valid_cnt), 32'd2);
    check("stop_single_done", 32'(done_cnt), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic reset_mid_test(input logic [22:0] base);
    int r, v;
    clear_counters();
    ready_mode = 0;
    expect_seq(base, int'(CW));
    select = base;
    start = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    check_idle_outputs("rst_mid");
    rst_n = 1'b1;
    exp_addr.delete();
    exp_smp.delete();
    r = rd_in_play;
    v = valid_cnt;
    repeat (10) tick();
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_no_reads", 32'(rd_in_play), 32'(r));
    check("rst_mid_no_valid", 32'(valid_cnt), 32'(v));
  endtask

`ifdef PLAY_ENGINE_LOOP_EN
  task automatic loop_test(input logic [22:0] base);
    int s;
    clear_counters();
    ready_mode = 0;
    expect_seq(base, 12);
    select = base;
    start = 1'b1;
    tick();
    for (int i = 0; i < 200 && hs_in_play < 9; i++) tick();
    stop = 1'b1;
    s = cyc;
    tick();
    stop = 1'b0;
    exp_addr.delete();
    exp_smp.delete();
    wait_done(10);
    check("loop_done_cycle", 32'(done_cyc), 32'(s + 1));
    repeat (10) tick();
    check("loop_hs", 32'(hs_in_play), 32'd9);
    check("loop_reads", 32'(rd_in_play), 32'd9);
    check("loop_single_done", 32'(done_cnt), 32'd1);
    start = 1'b0;
    repeat (3) tick();
    check("loop_busy", 32'(busy), 32'd0);
  endtask
`endif

  initial begin
    logic [22:0] b;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; select = '0;
    clear_counters();
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
`ifdef PLAY_ENGINE_LOOP_EN
    loop_test(23'h000100);
`else
    cadence_chk = 1'b1;
    run_play(23'h000100, 0, 1'b0);
    cadence_chk = 1'b0;
    bp_left = 10;
    run_play(23'($urandom), 2, 1'b0);
    check("bp_stall_cycles", 32'(stall_cnt), 32'd10);
    pause_test(23'($urandom));
    stop_test(23'($urandom));
    clear_counters();
    stop = 1'b1;
    repeat (3) tick();
    stop = 1'b0;
    check("idle_stop_busy", 32'(busy), 32'd0);
    check("idle_stop_done", 32'(done_cnt), 32'd0);
    run_play(23'h7FFFFE, 0, 1'b0);
    reset_mid_test(23'h000200);
    for (int n = 0; n < 6; n++) begin
      b = (n % 2 == 0) ? 23'($urandom) : 23'h7FFFFF - 23'($urandom_range(0, 3));
      run_play(b, 1, 1'b1);
    end
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
